// File: rtl/key_event_encoder_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg : shared key-event types and the lowest-set-bit helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_pkg;

  localparam int KEY_N      = 16;
  localparam int KEY_CODE_W = 4;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  press;
    logic                  rpt;
  } key_evt_t;

  // Descending walk so the last hit, which is the lowest index, wins
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [KEY_N-1:0] v);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_encoder_if.sv
// ---------------------------------------------------------------------------
// key_event_encoder_if : valid/ready key-event channel toward display/control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface key_event_encoder_if;
  import key_pkg::*;

  logic                  evt_valid;
  logic                  evt_ready;
  logic [KEY_CODE_W-1:0] evt_code;
  logic                  evt_press;
  logic                  evt_rpt;

  modport master (output evt_valid, evt_code, evt_press, evt_rpt, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_press, evt_rpt, output evt_ready);

endinterface

`default_nettype wire

// File: rtl/key_event_encoder_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo : synchronous key-event FIFO with a registered head word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_evt_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     RSTn,
  input  wire logic     i_push,
  input  wire key_evt_t i_din,
  input  wire logic     i_pop,
  output logic          o_full,
  output logic          o_empty,
  output key_evt_t      o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic          w_do_push;
  logic          w_do_pop;
  key_evt_t      r_mem [DEPTH];
  key_evt_t      r_head;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_wr_nxt  = r_wr_ptr + PW'(w_do_push);
  assign w_rd_nxt  = r_rd_ptr + PW'(w_do_pop);
  assign o_head    = r_head;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Head bypasses the array when the word being written becomes the new head
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      if (w_do_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) r_head <= i_din;
      else                                                      r_head <= r_mem[w_rd_nxt[AW-1:0]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_encoder.sv
// ---------------------------------------------------------------------------
// key_event_encoder : key level changes -> queued press/release/repeat events
// Optional auto-repeat compiled in with `define KEY_REPEAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_event_encoder
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  wire logic             clk,
  input  wire logic             RSTn,
  input  wire logic [KEY_N-1:0] key_deb,
  key_event_encoder_if.master   evt
);

  logic [KEY_N-1:0]      r_key_lvl;
  logic [KEY_N-1:0]      r_pend;
  logic [KEY_N-1:0]      w_served;
  logic [KEY_CODE_W-1:0] w_sel;
  logic                  w_has_pend;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_push_edge;
  logic                  w_push;
  key_evt_t              w_din;
  key_evt_t              w_head;

  assign w_has_pend  = |r_pend;
  assign w_sel       = lowest_set(r_pend);
  assign w_pop       = ~w_empty & evt.evt_ready;
  assign w_room      = ~w_full | w_pop;
  assign w_push_edge = w_has_pend & w_room;
  assign w_served    = w_push_edge ? (KEY_N'(1) << w_sel) : '0;

  // A bit re-toggling while pending stays set; its level is read at push time
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_key_lvl <= '0;
      r_pend    <= '0;
    end else begin
      r_key_lvl <= key_deb;
      r_pend    <= (r_pend & ~w_served) | (key_deb ^ r_key_lvl);
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Loading N-1 makes the repeat land exactly N cycles after the previous push
  localparam logic [CNT_W-1:0] C_DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_RATE_LD  = CNT_W'(REPEAT_RATE - 1);

  logic [KEY_CODE_W-1:0] r_held_key;
  logic                  r_held_vld;
  logic [CNT_W-1:0]      r_rpt_cnt;
  logic                  w_rpt_req;
  logic                  w_push_rpt;

  assign w_rpt_req  = r_held_vld & (r_rpt_cnt == '0);
  assign w_push_rpt = w_rpt_req & ~w_has_pend & w_room;
  assign w_push     = w_push_edge | w_push_rpt;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_held_key <= '0;
      r_held_vld <= 1'b0;
      r_rpt_cnt  <= '0;
    end else if (w_push_edge && r_key_lvl[w_sel]) begin
      r_held_key <= w_sel;
      r_held_vld <= 1'b1;
      r_rpt_cnt  <= C_DELAY_LD;
    end else if (w_push_edge && (w_sel == r_held_key)) begin
      r_held_vld <= 1'b0;
      r_rpt_cnt  <= '0;
    end else if (w_push_rpt) begin
      r_rpt_cnt  <= C_RATE_LD;
    end else if (r_held_vld && (r_rpt_cnt != '0)) begin
      r_rpt_cnt  <= r_rpt_cnt - 1'b1;
    end
  end

  always_comb begin
    w_din.code  = w_sel;
    w_din.press = r_key_lvl[w_sel];
    w_din.rpt   = 1'b0;
    if (!w_push_edge) begin
      w_din.code  = r_held_key;
      w_din.press = 1'b1;
      w_din.rpt   = 1'b1;
    end
  end

  assign evt.evt_rpt = w_head.rpt;
`else
  logic w_unused_cfg;

  assign w_push       = w_push_edge;
  assign w_unused_cfg = w_head.rpt ^ (REPEAT_DELAY > REPEAT_RATE);

  always_comb begin
    w_din.code  = w_sel;
    w_din.press = r_key_lvl[w_sel];
    w_din.rpt   = 1'b0;
  end

  assign evt.evt_rpt = 1'b0;
`endif

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .RSTn    (RSTn),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign evt.evt_valid = ~w_empty;
  assign evt.evt_code  = w_head.code;
  assign evt.evt_press = w_head.press;

endmodule

`default_nettype wire

// File: tb/tb_key_event_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_event_encoder : directed scoreboard bench for key_event_encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_event_encoder;
  import key_pkg::*;

  logic        clk = 1'b0;
  logic        RSTn;
  logic [15:0] key_deb;
  logic [5:0]  head6;
  logic [5:0]  mon_obs;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  logic [5:0]  exp_q [$];
  int          acc_q [$];

  key_event_encoder_if evt_if ();

  key_event_encoder #(
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8)
  ) dut (
    .clk     (clk),
    .RSTn    (RSTn),
    .key_deb (key_deb),
    .evt     (evt_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign head6 = {evt_if.evt_code, evt_if.evt_press, evt_if.evt_rpt};

  function automatic logic [5:0] ev(input int code, input bit press, input bit rpt);
    return {4'(code), press, rpt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every accepted event is popped against the scoreboard
  always @(negedge clk) begin
    if (RSTn === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      mon_obs = head6;
      acc_q.push_back(cyc);
      n_total++;
      assert (exp_q.size() != 0)
      else begin
        n_bad++;
        $error("FAIL sb_unexpected: observed=%0h expected=none", mon_obs);
      end
      if (exp_q.size() != 0) chk("sb_event", {26'd0, mon_obs}, {26'd0, exp_q.pop_front()});
    end
  end

  initial begin
    RSTn = 1'b0;
    key_deb = '0;
    evt_if.evt_ready = 1'b0;
    tick(3);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_code", evt_if.evt_code, 0);
    chk("rst_press", evt_if.evt_press, 0);
    chk("rst_rpt", evt_if.evt_rpt, 0);
    RSTn = 1'b1;
    tick(2);

    // single press: latency and content
    evt_if.evt_ready = 1'b1;
    tick(1);
    key_deb = 16'h0004;
    exp_q.push_back(ev(2, 1, 0));
    @(negedge clk); chk("t1_valid_pre", evt_if.evt_valid, 0);
    @(negedge clk); chk("t1_valid_k", evt_if.evt_valid, 0);
    @(negedge clk); chk("t1_valid_k1", evt_if.evt_valid, 1);
    chk("t1_head", head6, ev(2, 1, 0));
    tick(3);
    key_deb = 16'h0000;
    exp_q.push_back(ev(2, 0, 0));
    tick(6);
    chk("t1_drained", exp_q.size(), 0);

    // simultaneous edges serialised by ascending index
    key_deb = 16'h8011;
    exp_q.push_back(ev(0, 1, 0));
    exp_q.push_back(ev(4, 1, 0));
    exp_q.push_back(ev(15, 1, 0));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("t2_first", head6, ev(0, 1, 0));
    @(negedge clk); chk("t2_second", head6, ev(4, 1, 0));
    @(negedge clk); chk("t2_third", head6, ev(15, 1, 0));
    tick(3);
    key_deb = 16'h0000;
    exp_q.push_back(ev(0, 0, 0));
    exp_q.push_back(ev(4, 0, 0));
    exp_q.push_back(ev(15, 0, 0));
    tick(8);
    chk("t2_drained", exp_q.size(), 0);

    // back-pressure: 10 edges on keys 0..5, FIFO fills, rest held pending
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_deb[i] = 1'b1;
      tick(1);
    end
    for (int i = 0; i < 4; i++) begin
      key_deb[i] = 1'b0;
      tick(1);
    end
    tick(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(i, 1, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(i, 0, 0));
    exp_q.push_back(ev(4, 1, 0));
    exp_q.push_back(ev(5, 1, 0));
    @(negedge clk);
    chk("t3_full_valid", evt_if.evt_valid, 1);
    chk("t3_head", head6, ev(0, 1, 0));
    tick(3);
    @(negedge clk); chk("t3_head_stable", head6, ev(0, 1, 0));

    // one-cycle ready while full: pop and push on the same edge
    tick(1);
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    @(negedge clk); chk("t4_head_after_pp", head6, ev(1, 1, 0));
    tick(2);
    @(negedge clk); chk("t4_still_valid", evt_if.evt_valid, 1);
    tick(1);
    evt_if.evt_ready = 1'b1;
    tick(14);
    chk("t4_drained", exp_q.size(), 0);
    key_deb = 16'h0000;
    exp_q.push_back(ev(4, 0, 0));
    exp_q.push_back(ev(5, 0, 0));
    tick(6);
    chk("t4_rel_drained", exp_q.size(), 0);

    // held key 7: repeat timing, cancelled by release
    tick(1);
    key_deb = 16'h0080;
    acc_q.delete();
    exp_q.push_back(ev(7, 1, 0));
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(7, 1, 1));
`endif
    tick(38);
    key_deb = 16'h0000;
    exp_q.push_back(ev(7, 0, 0));
    tick(30);
`ifdef KEY_REPEAT_EN
    chk("t5_n_evts", acc_q.size(), 5);
    if (acc_q.size() == 5) begin
      chk("t5_gap_first", acc_q[1] - acc_q[0], 20);
      chk("t5_gap_second", acc_q[2] - acc_q[1], 8);
      chk("t5_gap_third", acc_q[3] - acc_q[2], 8);
    end
`else
    chk("t5_n_evts", acc_q.size(), 2);
`endif
    chk("t5_drained", exp_q.size(), 0);

    // reset with three queued releases discards them
    key_deb = 16'h0700;
    exp_q.push_back(ev(8, 1, 0));
    exp_q.push_back(ev(9, 1, 0));
    exp_q.push_back(ev(10, 1, 0));
    tick(8);
    evt_if.evt_ready = 1'b0;
    key_deb = 16'h0000;
    tick(6);
    @(negedge clk);
    chk("t6_queued_valid", evt_if.evt_valid, 1);
    chk("t6_head", head6, ev(8, 0, 0));
    exp_q.delete();
    #2 RSTn = 1'b0;
    #1 chk("t6_async_valid", evt_if.evt_valid, 0);
    tick(2);
    RSTn = 1'b1;
    evt_if.evt_ready = 1'b1;
    tick(12);
    @(negedge clk); chk("t6_post_valid", evt_if.evt_valid, 0);

    // encoder still works after reset
    tick(1);
    key_deb = 16'h0001;
    exp_q.push_back(ev(0, 1, 0));
    tick(6);
    chk("t6_post_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
